bpsk_modulator: RTL and testbench
=================================

Name: bpsk_modulator

Overview:
- Transmit-side BPSK modulator: the counterpart of the receive mixer, which downconverts the carrier.
- Accepts bytes over a valid/ready handshake and serializes them LSB-first.
- Emits a signed Q8.16 carrier sample stream with 0/180-degree phase per bit.
- Sits between the TX framer and the DAC interface; advances one sample per sample_en strobe.

Parameters:
DATA_WIDTH, 24, sample width (FIXDT_24_WIDTH)
DATA_FRAC_WIDTH, 16, fractional bits (FIXDT_24_FRAC_WIDTH); 24'sh010000 = 1.0
LUT_DEPTH, 16, samples per carrier cycle; power of two
CYCLES_PER_BIT, 2, carrier cycles per bit; SAMPLES_PER_BIT = LUT_DEPTH*CYCLES_PER_BIT = 32

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
sample_en  input  1  one-cycle strobe; advances modulator by one sample
in_data  input  8  byte to transmit
in_valid  input  1  in_data valid
in_ready  output  1  holding register empty; byte accepted when in_valid && in_ready
out_sample  output  DATA_WIDTH  signed Q8.16 modulated sample
out_valid  output  1  one-cycle pulse, out_sample updated
tx_active  output  1  high while a byte is being modulated
bit_out  output  1  current bit (debug/loopback)

Behaviour:
- Reset: all outputs forced immediately; out_sample=0, out_valid=0, tx_active=0, bit_out=0, in_ready=1. Holding register, shift register, counters and phase cleared. State=IDLE.
- Storage:
  - 1-byte holding register (hold_full) plus 8-bit shift register.
  - in_ready = !hold_full; registered, no combinational path from sample_en.
  - A handshake sets hold_full next cycle.
- States IDLE, SEND:
  - IDLE: on the first sample_en with hold_full=1, move hold into shift, clear hold_full, reset bit_cnt=0, sample_cnt=0, phase=0, go SEND. That sample_en also produces sample 0 of bit 0.
  - SEND: each sample_en outputs one sample, then sample_cnt++.
  - At sample_cnt==SAMPLES_PER_BIT-1: shift right, bit_cnt++.
  - After bit 7's last sample: if hold_full, reload shift and stay in SEND with no gap, phase continuing; else go IDLE.
- Sample: s = LUT[phase]; out_sample = bit ? s : -s (bit 1 = 0 deg, bit 0 = 180 deg).
  - phase = sample_cnt mod LUT_DEPTH, wrapping; bit boundaries align to carrier cycles.
  - Negation saturates: if s = 24'sh800000, the output is 24'sh7FFFFF. It is unreachable with the default LUT, but must still be implemented.
- Latency: sample_en in cycle n gives out_sample/out_valid in cycle n+1. out_sample holds between strobes. In IDLE, out_sample=0 and no out_valid.
- Simultaneous events:
  - Handshake in the same cycle as a reload: the reload empties hold, and the new byte fills it (hold_full stays 1).
  - sample_en while waiting in IDLE with hold empty: no output.
- tx_active = (state==SEND); bit_out = shift[0] during SEND, 0 in IDLE.
- rst_n assertion mid-byte aborts the byte immediately and drops the held byte. No partial-sample glitch: out_sample goes to 0.

Decomposition:
- Package bpsk_pkg holds:
  - state enum {IDLE, SEND}
  - carrier LUT constant (quarter-wave Q8.16): k0 0, k1 24'sh0061F8, k2 24'sh00B505, k3 24'sh00EC83, k4 24'sh010000, mirrored/negated for k5..k15
  - SAMPLES_PER_BIT function
- Sub-module bpsk_carrier_lut: combinational phase -> signed sample, with quarter-wave symmetry.

Test Plan:
- Reset, then drive in_valid=1, in_data=8'h01, sample_en every 4 clk -> sample0=0, sample1=24'sh0061F8, sample4=24'sh010000 (bit0=1). Sample 36 = 24'shFF0000 (bit1=0, -1.0). Exactly 256 out_valid pulses, then tx_active=0, out_sample=0.
- Bytes 8'hA5 then 8'h5A back-to-back, sample_en every clk -> 512 consecutive out_valid with no gap. in_ready low from accepting 5A until the reload at sample 256. bit_out sequence = 1,0,1,0,0,1,0,1 then 0,1,0,1,1,0,1,0.
- Offer a third byte while hold is full -> in_ready=0, byte not taken until the reload; handshake coincident with the reload is accepted.
- Assert rst_n=0 at sample 100 of byte 8'hFF -> same-cycle out_sample=0, tx_active=0, in_ready=1. After release, no residual output until a new byte is accepted.
- sample_en held low for 20 clk mid-byte -> out_sample and out_valid frozen (valid=0). Resume continues at the next phase index with no skipped sample.
- Force LUT entry 24'sh800000 (bench override) with bit=0 -> out_sample=24'sh7FFFFF.

Source files
------------

// File: rtl/bpsk_pkg.sv
// Shared types, sizes and carrier table for the BPSK transmit modulator.
// Samples are signed Q8.16; the table holds one quarter-wave of the carrier.
package bpsk_pkg;

   localparam int unsigned DATA_WIDTH      = 24;
   localparam int unsigned DATA_FRAC_WIDTH = 16;
   localparam int unsigned LUT_DEPTH       = 16;
   localparam int unsigned CYCLES_PER_BIT  = 2;
   localparam int unsigned BYTE_WIDTH      = 8;
   localparam int unsigned PHASE_WIDTH     = $clog2(LUT_DEPTH);
   localparam int unsigned QIDX_WIDTH      = PHASE_WIDTH - 1;

   function automatic int unsigned samples_per_bit();
      return LUT_DEPTH * CYCLES_PER_BIT;
   endfunction

   localparam int unsigned SAMPLES_PER_BIT = samples_per_bit();
   localparam int unsigned SCNT_WIDTH      = $clog2(SAMPLES_PER_BIT);
   localparam int unsigned BCNT_WIDTH      = $clog2(BYTE_WIDTH);

   typedef logic signed [DATA_WIDTH-1:0] sample_t;
   typedef logic [BYTE_WIDTH-1:0]        byte_t;

   typedef enum logic {
      IDLE = 1'b0,
      SEND = 1'b1
   } state_e;

   localparam sample_t SAMPLE_MAX = sample_t'({1'b0, {(DATA_WIDTH-1){1'b1}}});
   localparam sample_t SAMPLE_MIN = sample_t'({1'b1, {(DATA_WIDTH-1){1'b0}}});

   // Quarter-wave k0..k4; padded so any QIDX_WIDTH index is in range.
   localparam sample_t QTR_LUT [2**QIDX_WIDTH] = '{
      24'sh000000, 24'sh0061F8, 24'sh00B505, 24'sh00EC83,
      24'sh010000, 24'sh000000, 24'sh000000, 24'sh000000
   };

   // Negation that maps the most negative code to the most positive one.
   function automatic sample_t sat_neg(input sample_t s);
      return (s == SAMPLE_MIN) ? SAMPLE_MAX : -s;
   endfunction

endpackage

// File: rtl/bpsk_modulator_if.sv
// Byte input handshake from the TX framer into the modulator.
interface bpsk_modulator_if;
   import bpsk_pkg::*;

   byte_t in_data;
   logic  in_valid;
   logic  in_ready;

   modport master (output in_data, output in_valid, input  in_ready);
   modport slave  (input  in_data, input  in_valid, output in_ready);

endinterface

// File: rtl/bpsk_carrier_lut.sv
// Combinational carrier phase -> signed sample using quarter-wave symmetry.
// An optional single-entry patch lets an instance substitute one table value.
module bpsk_carrier_lut
   import bpsk_pkg::*;
#(
   parameter bit          PATCH_EN  = 1'b0,
   parameter int unsigned PATCH_IDX = 0,
   parameter sample_t     PATCH_VAL = '0
) (
   input  logic [PHASE_WIDTH-1:0] phase,
   output sample_t                sample_c
);

   logic [1:0]             quad_c;
   logic [PHASE_WIDTH-3:0] off_c;
   logic [QIDX_WIDTH-1:0]  qidx_c;
   sample_t                mag_c;

   // Odd quadrants read the table backwards, upper half is negated.
   always_comb begin
      quad_c   = phase[PHASE_WIDTH-1 -: 2];
      off_c    = phase[PHASE_WIDTH-3:0];
      qidx_c   = quad_c[0] ? (QIDX_WIDTH'(LUT_DEPTH / 4) - QIDX_WIDTH'(off_c))
                           : QIDX_WIDTH'(off_c);
      mag_c    = QTR_LUT[qidx_c];
      sample_c = quad_c[1] ? -mag_c : mag_c;
      if (PATCH_EN && (phase == PHASE_WIDTH'(PATCH_IDX))) begin
         sample_c = PATCH_VAL;
      end
   end

endmodule

// File: rtl/bpsk_modulator.sv
// BPSK transmit modulator: buffers one byte, serializes it LSB-first and
// emits one 0/180-degree carrier sample per sample_en strobe.
module bpsk_modulator
   import bpsk_pkg::*;
#(
   parameter bit          LUT_PATCH_EN  = 1'b0,
   parameter int unsigned LUT_PATCH_IDX = 0,
   parameter sample_t     LUT_PATCH_VAL = '0
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            sample_en,
   bpsk_modulator_if.slave in_if,
   output sample_t         out_sample,
   output logic            out_valid,
   output logic            tx_active,
   output logic            bit_out
);

   state_e                 state_q, state_d;
   byte_t                  hold_q, hold_d;
   byte_t                  shift_q, shift_d;
   logic                   hold_full_q, hold_full_d;
   logic [BCNT_WIDTH-1:0]  bit_cnt_q, bit_cnt_d;
   logic [SCNT_WIDTH-1:0]  sample_cnt_q, sample_cnt_d;
   sample_t                out_sample_q, out_sample_d;
   logic                   out_valid_q, out_valid_d;
   logic                   in_ready_q, in_ready_d;
   logic                   tx_active_q, tx_active_d;
   logic                   bit_out_q, bit_out_d;

   logic [PHASE_WIDTH-1:0] phase_c;
   logic                   cur_bit_c;
   sample_t                carrier_c;
   logic                   handshake_c;
   logic                   last_sample_c;
   logic                   last_bit_c;
   logic                   load_c;
   logic                   emit_c;

   // In IDLE the strobe that starts a byte plays sample 0 of the held byte.
   assign phase_c       = (state_q == IDLE) ? '0 : sample_cnt_q[PHASE_WIDTH-1:0];
   assign cur_bit_c     = (state_q == IDLE) ? hold_q[0] : shift_q[0];
   assign handshake_c   = in_if.in_valid && in_ready_q;
   assign last_sample_c = (sample_cnt_q == SCNT_WIDTH'(SAMPLES_PER_BIT - 1));
   assign last_bit_c    = (bit_cnt_q == BCNT_WIDTH'(BYTE_WIDTH - 1));

   bpsk_carrier_lut #(
      .PATCH_EN  (LUT_PATCH_EN),
      .PATCH_IDX (LUT_PATCH_IDX),
      .PATCH_VAL (LUT_PATCH_VAL)
   ) u_lut (
      .phase    (phase_c),
      .sample_c (carrier_c)
   );

   always_comb begin
      state_d      = state_q;
      hold_d       = hold_q;
      hold_full_d  = hold_full_q;
      shift_d      = shift_q;
      bit_cnt_d    = bit_cnt_q;
      sample_cnt_d = sample_cnt_q;
      out_sample_d = out_sample_q;
      out_valid_d  = 1'b0;
      load_c       = 1'b0;
      emit_c       = 1'b0;

      case (state_q)
         IDLE: begin
            out_sample_d = '0;
            if (sample_en && hold_full_q) begin
               load_c       = 1'b1;
               emit_c       = 1'b1;
               sample_cnt_d = SCNT_WIDTH'(1);
               state_d      = SEND;
            end
         end
         SEND: begin
            if (sample_en) begin
               emit_c = 1'b1;
               if (!last_sample_c) begin
                  sample_cnt_d = sample_cnt_q + SCNT_WIDTH'(1);
               end else begin
                  sample_cnt_d = '0;
                  if (!last_bit_c) begin
                     shift_d   = shift_q >> 1;
                     bit_cnt_d = bit_cnt_q + BCNT_WIDTH'(1);
                  end else if (hold_full_q) begin
                     load_c = 1'b1;
                  end else begin
                     shift_d   = '0;
                     bit_cnt_d = '0;
                     state_d   = IDLE;
                  end
               end
            end
         end
         default: state_d = IDLE;
      endcase

      // A handshake in the same cycle as a reload refills the holding register.
      if (load_c) begin
         shift_d     = hold_q;
         hold_full_d = 1'b0;
         bit_cnt_d   = '0;
      end
      if (handshake_c) begin
         hold_d      = in_if.in_data;
         hold_full_d = 1'b1;
      end

      if (emit_c) begin
         out_valid_d  = 1'b1;
         out_sample_d = cur_bit_c ? carrier_c : sat_neg(carrier_c);
      end

      in_ready_d  = !hold_full_d;
      tx_active_d = (state_d == SEND);
      bit_out_d   = (state_d == SEND) && shift_d[0];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         hold_q       <= '0;
         hold_full_q  <= 1'b0;
         shift_q      <= '0;
         bit_cnt_q    <= '0;
         sample_cnt_q <= '0;
         out_sample_q <= '0;
         out_valid_q  <= 1'b0;
         in_ready_q   <= 1'b1;
         tx_active_q  <= 1'b0;
         bit_out_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         hold_q       <= hold_d;
         hold_full_q  <= hold_full_d;
         shift_q      <= shift_d;
         bit_cnt_q    <= bit_cnt_d;
         sample_cnt_q <= sample_cnt_d;
         out_sample_q <= out_sample_d;
         out_valid_q  <= out_valid_d;
         in_ready_q   <= in_ready_d;
         tx_active_q  <= tx_active_d;
         bit_out_q    <= bit_out_d;
      end
   end

   assign in_if.in_ready = in_ready_q;
   assign out_sample     = out_sample_q;
   assign out_valid      = out_valid_q;
   assign tx_active      = tx_active_q;
   assign bit_out        = bit_out_q;

endmodule

// File: tb/tb_bpsk_modulator.sv
// Self-checking bench: directed scenarios plus random traffic, compared every
// cycle against a byte/sample-level model of the modulator.
module tb_bpsk_modulator;
   import bpsk_pkg::*;

   localparam int SPB          = 32;
   localparam int BYTE_SAMPLES = 8 * SPB;
   localparam int NPH          = 16;
   // round(65536 * sin(2*pi*k/16))
   localparam int REF_SINE [NPH] = '{
           0,  25080,  46341,  60547,  65536,  60547,  46341,  25080,
           0, -25080, -46341, -60547, -65536, -60547, -46341, -25080
   };

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic sample_en = 1'b0;
   always #5 clk = ~clk;

   bpsk_modulator_if dut_if ();
   bpsk_modulator_if sat_if ();

   sample_t out_sample, sat_sample;
   logic    out_valid, tx_active, bit_out;
   logic    sat_valid, sat_active, sat_bit;

   bpsk_modulator u_dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .sample_en  (sample_en),
      .in_if      (dut_if),
      .out_sample (out_sample),
      .out_valid  (out_valid),
      .tx_active  (tx_active),
      .bit_out    (bit_out)
   );

   bpsk_modulator #(
      .LUT_PATCH_EN  (1'b1),
      .LUT_PATCH_IDX (4),
      .LUT_PATCH_VAL (24'sh800000)
   ) u_sat (
      .clk        (clk),
      .rst_n      (rst_n),
      .sample_en  (sample_en),
      .in_if      (sat_if),
      .out_sample (sat_sample),
      .out_valid  (sat_valid),
      .tx_active  (sat_active),
      .bit_out    (sat_bit)
   );

   int checks = 0;
   int errors = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
      end
   endtask

   // ---------------- reference model (byte/sample level) ----------------
   bit          m_active, m_valid, m_hs, m_bit, m_ready;
   logic [7:0]  m_cur;
   int          m_cnt;
   int          m_sample;
   logic [7:0]  m_pend_q [$];
   int          dut_log [$];
   int          sat_log [$];

   function automatic int ref_sample(input logic [7:0] b, input int n);
      int s;
      s = REF_SINE[n % NPH];
      if (((b >> (n / SPB)) & 8'h01) == 8'h00) s = -s;
      if (s > 8388607)  s = 8388607;
      if (s < -8388608) s = -8388608;
      return s;
   endfunction

   function automatic int q_at(input int q [$], input int i);
      return (i < q.size()) ? q[i] : 32'h7EADBEEF;
   endfunction

   function automatic void model_reset();
      m_active = 1'b0; m_valid = 1'b0; m_hs = 1'b0; m_bit = 1'b0; m_ready = 1'b1;
      m_cur = 8'h00; m_cnt = 0; m_sample = 0;
      m_pend_q.delete();
   endfunction

   task automatic model_edge();
      bit act_pre, rdy_pre;
      if (!rst_n) begin
         model_reset();
         return;
      end
      act_pre = m_active;
      rdy_pre = (m_pend_q.size() == 0);
      m_valid = 1'b0;
      m_hs    = 1'b0;
      if (sample_en) begin
         if (!m_active && m_pend_q.size() != 0) begin
            m_cur = m_pend_q.pop_front();
            m_cnt = 0;
            m_active = 1'b1;
         end
         if (m_active) begin
            m_sample = ref_sample(m_cur, m_cnt);
            m_valid  = 1'b1;
            m_cnt++;
            if (m_cnt == BYTE_SAMPLES) begin
               if (m_pend_q.size() != 0) begin
                  m_cur = m_pend_q.pop_front();
                  m_cnt = 0;
               end else begin
                  m_active = 1'b0;
               end
            end
         end
      end
      if (!m_valid && !act_pre) m_sample = 0;
      if (dut_if.in_valid && rdy_pre) begin
         m_pend_q.push_back(dut_if.in_data);
         m_hs = 1'b1;
      end
      m_ready = (m_pend_q.size() == 0);
      m_bit   = m_active && (((m_cur >> (m_cnt / SPB)) & 8'h01) != 8'h00);
   endtask

   task automatic compare_all();
      check_eq("out_valid",  32'(out_valid),       32'(m_valid));
      check_eq("out_sample", 32'(out_sample),      m_sample);
      check_eq("in_ready",   32'(dut_if.in_ready), 32'(m_ready));
      check_eq("tx_active",  32'(tx_active),       32'(m_active));
      check_eq("bit_out",    32'(bit_out),         32'(m_bit));
   endtask

   task automatic tick();
      @(posedge clk);
      model_edge();
      @(negedge clk);
      compare_all();
      if (out_valid) dut_log.push_back(int'(out_sample));
   endtask

   always @(negedge clk) if (sat_valid) sat_log.push_back(int'(sat_sample));

   initial begin
      byte_t      bytes [3];
      logic [23:0] cap;
      int         idx, run, max_run, vidx, nval, dens;
      bit         done;

      dut_if.in_valid = 1'b0; dut_if.in_data = 8'h00;
      sat_if.in_valid = 1'b0; sat_if.in_data = 8'h00;
      model_reset();
      repeat (3) @(negedge clk);
      compare_all();
      rst_n = 1'b1;

      // Single byte 0x01 with a strobe every 4 clocks; saturation instance gets 0x00.
      dut_if.in_valid = 1'b1; dut_if.in_data = 8'h01;
      sat_if.in_valid = 1'b1; sat_if.in_data = 8'h00;
      tick();
      dut_if.in_valid = 1'b0; sat_if.in_valid = 1'b0;
      dut_log.delete();
      for (int c = 0; c < 1040; c++) begin
         sample_en = (c % 4 == 0);
         tick();
      end
      sample_en = 1'b0;
      check_eq("tp1_count",   32'(dut_log.size()), 256);
      check_eq("tp1_s0",      q_at(dut_log, 0),  32'h00000000);
      check_eq("tp1_s1",      q_at(dut_log, 1),  32'h000061F8);
      check_eq("tp1_s4",      q_at(dut_log, 4),  32'h00010000);
      check_eq("tp1_s36",     q_at(dut_log, 36), 32'hFFFF0000);
      check_eq("tp1_idle_sample", 32'(out_sample), 0);
      check_eq("tp1_idle_active", 32'(tx_active),  0);
      check_eq("sat_s4",      q_at(sat_log, 4),  32'h007FFFFF);
      check_eq("sat_s5",      q_at(sat_log, 5),  -60547);
      check_eq("sat_s20",     q_at(sat_log, 20), 32'h007FFFFF);

      // A5, 5A, then C3 offered while the holding register is full.
      bytes = '{8'hA5, 8'h5A, 8'hC3};
      idx = 0; run = 0; max_run = 0; vidx = 0; cap = '0; done = 1'b0;
      sample_en = 1'b1;
      dut_if.in_valid = 1'b1; dut_if.in_data = bytes[0];
      for (int c = 0; c < 2000 && !done; c++) begin
         tick();
         if (out_valid) begin
            if (vidx % SPB == SPB / 2 && vidx / SPB < 24) cap[vidx / SPB] = bit_out;
            vidx++;
            run++;
            if (run > max_run) max_run = run;
         end else begin
            run = 0;
         end
         if (m_hs) begin
            idx++;
            if (idx < 3) dut_if.in_data = bytes[idx];
            else dut_if.in_valid = 1'b0;
         end
         if (idx == 3 && !m_active && m_pend_q.size() == 0) done = 1'b1;
      end
      check_eq("tp2_done",    32'(done), 1);
      check_eq("tp2_run",     32'(max_run), 3 * BYTE_SAMPLES);
      check_eq("tp2_bits",    32'(cap), 32'({bytes[2], bytes[1], bytes[0]}));

      // Byte 0x96 with a 20-clock strobe gap at sample 50.
      dut_if.in_valid = 1'b1; dut_if.in_data = 8'h96;
      tick();
      dut_if.in_valid = 1'b0;
      nval = 0;
      for (int c = 0; c < 100 && nval < 50; c++) begin
         tick();
         if (out_valid) nval++;
      end
      check_eq("stall_reach", 32'(nval), 50);
      sample_en = 1'b0;
      repeat (20) tick();
      sample_en = 1'b1;
      done = 1'b0;
      for (int c = 0; c < 400 && !done; c++) begin
         tick();
         if (!m_active) done = 1'b1;
      end
      check_eq("stall_done", 32'(done), 1);

      // Reset at sample 100 of 0xFF, with 0x3C waiting in the holding register.
      dut_if.in_valid = 1'b1; dut_if.in_data = 8'hFF;
      tick();
      dut_if.in_data = 8'h3C;
      done = 1'b0;
      for (int c = 0; c < 300 && !done; c++) begin
         tick();
         if (m_hs) dut_if.in_valid = 1'b0;
         if (m_active && m_cnt == 100) done = 1'b1;
      end
      check_eq("rst_reach", 32'(done), 1);
      dut_if.in_valid = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      check_eq("rst_sample", 32'(out_sample),      0);
      check_eq("rst_valid",  32'(out_valid),       0);
      check_eq("rst_active", 32'(tx_active),       0);
      check_eq("rst_ready",  32'(dut_if.in_ready), 1);
      model_reset();
      repeat (2) tick();
      rst_n = 1'b1;
      repeat (40) tick();

      // Random traffic at several strobe densities.
      for (int blk = 0; blk < 6; blk++) begin
         dens = (blk % 3 == 0) ? 100 : ((blk % 3 == 1) ? 60 : 25);
         for (int c = 0; c < 500; c++) begin
            sample_en       = ($urandom_range(0, 99) < dens);
            dut_if.in_valid = ($urandom_range(0, 3) == 0);
            dut_if.in_data  = 8'($urandom);
            tick();
         end
      end

      dut_if.in_valid = 1'b0;
      sample_en = 1'b1;
      done = 1'b0;
      for (int c = 0; c < 1200 && !done; c++) begin
         tick();
         if (!m_active && m_pend_q.size() == 0) done = 1'b1;
      end
      check_eq("drain_done", 32'(done), 1);
      repeat (2) tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
